// File: rtl/am_motor_seq.sv
// Alignment-motor sequencer: turns per-frame alignment results into bounded
// stepper moves, repeating measure->move until aligned, out of tries, or aborted.
module am_motor_seq #(
  parameter int C_STEP_NUMBER_WIDTH = 32,
  parameter int C_SPEED_DATA_WIDTH  = 32,
  parameter int C_TRY_WIDTH         = 8
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic                                  req_en,
  input  logic        [C_SPEED_DATA_WIDTH-1:0]  req_speed,
  input  logic        [C_STEP_NUMBER_WIDTH-1:0] req_max_step,
  input  logic        [C_TRY_WIDTH-1:0]         req_max_try,
  input  logic                                  i_pulse,
  input  logic signed [C_STEP_NUMBER_WIDTH-1:0] i_step,
  input  logic                                  i_ok,
  input  logic                                  i_should_start,
  input  logic                                  m_state,
  output logic                                  m_start,
  output logic                                  m_stop,
  output logic                                  m_dir,
  output logic        [C_STEP_NUMBER_WIDTH-1:0] m_step,
  output logic        [C_SPEED_DATA_WIDTH-1:0]  m_speed,
  output logic                                  o_busy,
  output logic                                  o_done,
  output logic                                  o_err,
  output logic        [C_TRY_WIDTH-1:0]         o_try_cnt,
  output logic        [2:0]                     dbg_state
);

  localparam int W = C_STEP_NUMBER_WIDTH;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_IMG = 3'd1;
  localparam logic [2:0] S_WAIT_ACK = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_STOP     = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam logic [W-1:0] STEP_MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] STEP_MAX_POS  = {1'b0, {(W-1){1'b1}}};

  // Handshakes: i_pulse is a one-cycle strobe qualifying i_step/i_ok/i_should_start
  // with no back-pressure; m_start/m_stop are one-cycle commands and m_state is the
  // controller's level response (1 = running), acting as the acknowledge for m_start.
  logic [2:0]       state;
  logic             req_en_d;
  logic [15:0]      ack_tmr;
  logic [W-1:0]     mag_abs;
  logic [W-1:0]     mag_clamp;
  logic             try_limit;
  logic             req_rise;

  always_comb begin
    mag_abs = i_step[W-1] ? W'(-i_step) : W'(i_step);
    if (W'(i_step) == STEP_MOST_NEG) mag_abs = STEP_MAX_POS;
    mag_clamp = mag_abs;
    if ((req_max_step != '0) && (mag_abs > req_max_step)) mag_clamp = req_max_step;
  end

  assign try_limit = (req_max_try != '0) && (o_try_cnt == req_max_try);
  assign req_rise  = req_en & ~req_en_d;
  assign o_busy    = (state == S_WAIT_IMG) || (state == S_WAIT_ACK) ||
                     (state == S_RUN) || (state == S_STOP);
  assign o_done    = (state == S_DONE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      req_en_d  <= 1'b0;
      ack_tmr   <= '0;
      m_start   <= 1'b0;
      m_stop    <= 1'b0;
      m_dir     <= 1'b0;
      m_step    <= '0;
      m_speed   <= '0;
      o_err     <= 1'b0;
      o_try_cnt <= '0;
    end else begin
      req_en_d <= req_en;
      m_start  <= 1'b0;
      m_stop   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_rise) begin
            o_try_cnt <= '0;
            o_err     <= 1'b0;
            state     <= S_WAIT_IMG;
          end
        end
        S_WAIT_IMG: begin
          if (!req_en) begin
            if (m_state) begin
              m_stop <= 1'b1;
              state  <= S_STOP;
            end else begin
              state  <= S_IDLE;
            end
          end else if (i_pulse) begin
            if (i_ok) begin
              o_err <= 1'b0;
              state <= S_DONE;
            end else if (try_limit) begin
              o_err <= 1'b1;
              state <= S_DONE;
            end else if (i_should_start && (i_step != '0)) begin
              m_start <= 1'b1;
              m_dir   <= i_step[W-1];
              m_step  <= mag_clamp;
              m_speed <= req_speed;
              ack_tmr <= '0;
              if (o_try_cnt != '1) o_try_cnt <= o_try_cnt + 1'b1;
              state   <= S_WAIT_ACK;
            end
          end
        end
        S_WAIT_ACK: begin
          // A move was commanded, so abort always stops even if not yet acknowledged.
          if (!req_en) begin
            m_stop <= 1'b1;
            state  <= S_STOP;
          end else if (m_state) begin
            state <= S_RUN;
          end else if (ack_tmr == 16'hFFFF) begin
            o_err <= 1'b1;
            state <= S_DONE;
          end else begin
            ack_tmr <= ack_tmr + 16'd1;
          end
        end
        S_RUN: begin
          if (!req_en) begin
            if (m_state) begin
              m_stop <= 1'b1;
              state  <= S_STOP;
            end else begin
              state  <= S_IDLE;
            end
          end else if (!m_state) begin
            state <= S_WAIT_IMG;
          end
        end
        S_STOP: begin
          if (!m_state) state <= S_IDLE;
        end
        S_DONE: begin
          if (!req_en) begin
            o_err <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
